// File: rtl/remote_comm_link_pkg.sv
// Shared constants and types for the host-side robot command/response link.
package remote_comm_link_pkg;

  localparam int unsigned BaudDivDefault = 2604;  // 50 MHz / 19200 baud
  localparam logic [7:0]  Ack            = 8'hA5;

  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StLow
  } cmd_state_e;

endpackage

// File: rtl/remote_comm_link_uart_xcvr.sv
// 8N1 UART transmitter/receiver pair; each bit lasts BAUD_DIV clocks.
module uart_xcvr
  import remote_comm_link_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BaudDivDefault
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       tx,
  input  logic       rx,
  input  logic       clr_rx_rdy,
  output logic       rx_rdy,
  output logic [7:0] rx_data
);

  localparam int unsigned CntW = $clog2(BAUD_DIV);
  localparam logic [CntW-1:0] BitLast  = CntW'(BAUD_DIV - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(BAUD_DIV / 2 - 1);

  logic            tx_busy_q, tx_q, tx_done_q;
  logic [3:0]      tx_bit_q;
  logic [CntW-1:0] tx_cnt_q;
  logic [8:0]      tx_shift_q;

  logic            rx_s1_q, rx_s2_q, rx_prev_q;
  logic            rx_busy_q, rx_rdy_q;
  logic [3:0]      rx_bit_q;
  logic [CntW-1:0] rx_cnt_q;
  logic [7:0]      rx_shift_q, rx_data_q;
  logic            rx_fall;

  assign tx      = tx_q;
  assign tx_done = tx_done_q;
  assign rx_rdy  = rx_rdy_q;
  assign rx_data = rx_data_q;
  assign rx_fall = rx_prev_q & ~rx_s2_q;

  // tx_bit_q: 0 = start, 1..8 = data, 9 = stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_busy_q  <= 1'b0;
      tx_q       <= 1'b1;
      tx_done_q  <= 1'b0;
      tx_bit_q   <= '0;
      tx_cnt_q   <= '0;
      tx_shift_q <= '1;
    end else begin
      tx_done_q <= 1'b0;
      if (!tx_busy_q) begin
        if (trmt) begin
          tx_busy_q  <= 1'b1;
          tx_q       <= 1'b0;
          tx_shift_q <= {1'b1, tx_data};
          tx_bit_q   <= '0;
          tx_cnt_q   <= '0;
        end
      end else if (tx_cnt_q == BitLast) begin
        tx_cnt_q <= '0;
        if (tx_bit_q == 4'd9) begin
          tx_busy_q <= 1'b0;
          tx_done_q <= 1'b1;
        end else begin
          tx_q       <= tx_shift_q[0];
          tx_shift_q <= {1'b1, tx_shift_q[8:1]};
          tx_bit_q   <= tx_bit_q + 4'd1;
        end
      end else begin
        tx_cnt_q <= tx_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_busy_q  <= 1'b0;
      rx_rdy_q   <= 1'b0;
      rx_bit_q   <= '0;
      rx_cnt_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      if (clr_rx_rdy) rx_rdy_q <= 1'b0;
      if (!rx_busy_q) begin
        if (rx_fall) begin
          rx_busy_q <= 1'b1;
          rx_bit_q  <= '0;
          rx_cnt_q  <= '0;
        end
      end else if (rx_cnt_q == ((rx_bit_q == 4'd0) ? HalfLast : BitLast)) begin
        rx_cnt_q <= '0;
        if (rx_bit_q == 4'd0) begin
          // Start bit high at mid-point: treat as a glitch.
          if (rx_s2_q) rx_busy_q <= 1'b0;
          else         rx_bit_q  <= 4'd1;
        end else if (rx_bit_q == 4'd9) begin
          rx_busy_q <= 1'b0;
          rx_data_q <= rx_shift_q;
          rx_rdy_q  <= 1'b1;
        end else begin
          rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_q   <= rx_bit_q + 4'd1;
        end
      end else begin
        rx_cnt_q <= rx_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/remote_comm_link.sv
// Host link: sends a 16-bit command as two UART bytes (high first), returns response bytes.
module remote_comm_link
  import remote_comm_link_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BaudDivDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        send_cmd,
  output logic        cmd_sent,
  input  logic        RX,
  output logic        TX,
  output logic [7:0]  resp,
  output logic        resp_rdy
);

  cmd_state_e  state_q, state_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cmd_sent_q, cmd_sent_d;
  logic        launch_q, launch_d;
  logic        accept;
  logic        tx_done;
  logic [7:0]  tx_data;

  assign cmd_sent = cmd_sent_q;
  assign tx_data  = (state_q == StLow) ? cmd_q[7:0] : cmd_q[15:8];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cmd_q      <= '0;
      cmd_sent_q <= 1'b0;
      launch_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      cmd_sent_q <= cmd_sent_d;
      launch_q   <= launch_d;
    end
  end

  // launch_q pulses trmt once on entry to each byte state.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    cmd_sent_d = cmd_sent_q;
    launch_d   = 1'b0;
    accept     = 1'b0;
    case (state_q)
      StIdle: begin
        if (send_cmd) begin
          accept     = 1'b1;
          cmd_d      = cmd;
          cmd_sent_d = 1'b0;
          launch_d   = 1'b1;
          state_d    = StHigh;
        end
      end
      StHigh: begin
        if (tx_done) begin
          launch_d = 1'b1;
          state_d  = StLow;
        end
      end
      StLow: begin
        if (tx_done) begin
          cmd_sent_d = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  uart_xcvr #(
    .BAUD_DIV(BAUD_DIV)
  ) u_xcvr (
    .clk       (clk),
    .rst       (rst),
    .trmt      (launch_q),
    .tx_data   (tx_data),
    .tx_done   (tx_done),
    .tx        (TX),
    .rx        (RX),
    .clr_rx_rdy(accept),
    .rx_rdy    (resp_rdy),
    .rx_data   (resp)
  );

endmodule

// File: tb/tb_remote_comm_link.sv
// Scoreboarded bench for remote_comm_link: TX frames decoded against an expected-byte queue.
module tb_remote_comm_link;
  import remote_comm_link_pkg::*;

  localparam int B = 16;

  logic        clk, rst, send_cmd, cmd_sent, tx, resp_rdy;
  logic        bench_rx, loop, rx_line;
  logic [15:0] cmd;
  logic [7:0]  resp;
  logic [7:0]  exp_q[$];
  int          n_checks, n_pass;

  assign rx_line = loop ? tx : bench_rx;

  remote_comm_link #(
    .BAUD_DIV(B)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cmd     (cmd),
    .send_cmd(send_cmd),
    .cmd_sent(cmd_sent),
    .RX      (rx_line),
    .TX      (tx),
    .resp    (resp),
    .resp_rdy(resp_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // TX monitor: decode each frame at mid-bit and compare with the scoreboard.
  initial begin
    logic [9:0] frame;
    logic [7:0] expb;
    bit aborted;
    forever begin
      @(negedge tx);
      aborted = 1'b0;
      for (int b = 0; b < 10; b++) begin
        repeat ((b == 0) ? B / 2 : B) begin
          @(posedge clk);
          #1;
          if (rst) aborted = 1'b1;
        end
        frame[b] = tx;
      end
      if (!aborted) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL tx_unexpected: got frame %b, required no frame", frame);
        end else begin
          expb = exp_q.pop_front();
          if (frame !== {1'b1, expb, 1'b0})
            $display("FAIL tx_frame: got %b, required %b", frame, {1'b1, expb, 1'b0});
          else n_pass++;
        end
      end
    end
  end

  task automatic send(input logic [15:0] c);
    @(negedge clk);
    cmd = c;
    send_cmd = 1'b1;
    @(negedge clk);
    send_cmd = 1'b0;
  endtask

  task automatic wait_sent(input int bound, output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    while (n < bound && !ok) begin
      @(posedge clk);
      #1;
      n++;
      if (cmd_sent) ok = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    @(negedge clk);
    bench_rx = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bench_rx = d[i];
      repeat (B) @(negedge clk);
    end
    bench_rx = 1'b1;
    repeat (B) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    n_checks++;
    if (tx !== 1'b1) $display("FAIL reset_tx: got %b, required 1", tx); else n_pass++;
    n_checks++;
    if (cmd_sent !== 1'b0) $display("FAIL reset_cmd_sent: got %b, required 0", cmd_sent);
    else n_pass++;
    n_checks++;
    if (resp_rdy !== 1'b0) $display("FAIL reset_resp_rdy: got %b, required 0", resp_rdy);
    else n_pass++;
    n_checks++;
    if (resp !== 8'h00) $display("FAIL reset_resp: got %h, required 00", resp); else n_pass++;
  endtask

  task automatic test_ack();
    int n;
    fork
      send_byte(Ack);
      begin
        @(negedge clk);
        n = 0;
        while (n < 12 * B && resp !== Ack) begin
          @(posedge clk);
          #1;
          n++;
        end
      end
    join
    n_checks++;
    if (n < 9 * B || n > 10 * B) $display("FAIL ack_latency: got %0d clocks, required %0d..%0d", n, 9 * B, 10 * B);
    else n_pass++;
    n_checks++;
    if (resp !== Ack) $display("FAIL ack_resp: got %h, required %h", resp, Ack); else n_pass++;
    n_checks++;
    if (resp_rdy !== 1'b1) $display("FAIL ack_resp_rdy: got %b, required 1", resp_rdy);
    else n_pass++;
  endtask

  task automatic test_glitch();
    @(negedge clk);
    bench_rx = 1'b0;
    repeat (3) @(negedge clk);
    bench_rx = 1'b1;
    repeat (12 * B) @(negedge clk);
    n_checks++;
    if (resp !== Ack) $display("FAIL glitch_resp: got %h, required %h", resp, Ack); else n_pass++;
  endtask

  task automatic test_calibrate();
    int n;
    bit ok;
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h00);
    send(16'h2000);
    n_checks++;
    if (resp_rdy !== 1'b0) $display("FAIL cal_clear_rdy: got %b, required 0", resp_rdy);
    else n_pass++;
    wait_sent(22 * B, n, ok);
    n_checks++;
    if (!ok || n < 20 * B || n > 20 * B + 8)
      $display("FAIL cal_latency: got ok=%0d n=%0d, required n in %0d..%0d", ok, n, 20 * B, 20 * B + 8);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL cal_drained: got %0d bytes left, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_loopback();
    int n;
    bit ok;
    loop = 1'b1;
    exp_q.push_back(8'h40);
    exp_q.push_back(8'h01);
    send(16'h4001);
    n = 0;
    while (n < 12 * B && resp !== 8'h40) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_checks++;
    if (resp !== 8'h40) $display("FAIL loop_first: got %h, required 40", resp); else n_pass++;
    n_checks++;
    if (resp_rdy !== 1'b1) $display("FAIL loop_first_rdy: got %b, required 1", resp_rdy);
    else n_pass++;
    wait_sent(12 * B, n, ok);
    n_checks++;
    if (!ok || resp !== 8'h01) $display("FAIL loop_second: got ok=%0d resp=%h, required ok=1 resp=01", ok, resp);
    else n_pass++;
    loop = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n;
    bit ok;
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    send(16'h3344);
    repeat (5 * B) @(negedge clk);
    cmd = 16'h6112;
    send_cmd = 1'b1;
    @(negedge clk);
    send_cmd = 1'b0;
    cmd = 16'h0000;
    wait_sent(22 * B, n, ok);
    n_checks++;
    if (!ok) $display("FAIL b2b_sent: got cmd_sent=%b, required 1", cmd_sent); else n_pass++;
    repeat (12 * B) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL b2b_drained: got %0d bytes left, required 0", exp_q.size());
    else n_pass++;
    n_checks++;
    if (cmd_sent !== 1'b1) $display("FAIL b2b_idle: got cmd_sent=%b, required 1", cmd_sent);
    else n_pass++;
  endtask

  task automatic test_reset_midop();
    int n;
    bit ok;
    logic [7:0] d;
    d = 8'h3C;
    exp_q.push_back(8'h0F);
    exp_q.push_back(8'h66);
    send(16'h0F66);
    repeat (B) @(negedge clk);
    bench_rx = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bench_rx = d[i];
      repeat (B) @(negedge clk);
    end
    bench_rx = d[3];
    repeat (B / 2) @(negedge clk);
    rst = 1'b1;
    bench_rx = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (tx !== 1'b1) $display("FAIL rst_mid_tx: got %b, required 1", tx); else n_pass++;
    n_checks++;
    if (resp !== 8'h00) $display("FAIL rst_mid_resp: got %h, required 00", resp); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    repeat (25 * B) @(negedge clk);
    n_checks++;
    if (cmd_sent !== 1'b0) $display("FAIL rst_mid_cmd_sent: got %b, required 0", cmd_sent);
    else n_pass++;
    n_checks++;
    if (resp_rdy !== 1'b0) $display("FAIL rst_mid_resp_rdy: got %b, required 0", resp_rdy);
    else n_pass++;
    exp_q.push_back(8'h7E);
    exp_q.push_back(8'h81);
    send(16'h7E81);
    wait_sent(22 * B, n, ok);
    n_checks++;
    if (!ok) $display("FAIL rst_clean_sent: got cmd_sent=%b, required 1", cmd_sent); else n_pass++;
    repeat (2 * B) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL rst_clean_drained: got %0d bytes left, required 0", exp_q.size());
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    send_cmd = 1'b0;
    cmd      = 16'h0000;
    bench_rx = 1'b1;
    loop     = 1'b0;
    test_reset();
    test_ack();
    test_glitch();
    test_calibrate();
    test_loopback();
    test_back_to_back();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/remote_comm_link.md
Name: remote_comm_link

Overview:
- Host-side command/response link for the knight's-tour robot.
- Takes a 16-bit command and serialises it over 8N1 UART as two bytes, high byte first, into the robot's RX pin.
- Receives single-byte responses from the robot's TX pin, e.g. 0xA5 acknowledge after calibration or a completed move.
- Used as the remote-controller model in system benches and as the reference host interface.

Parameters:
- BAUD_DIV, default 2604: clocks per UART bit (50 MHz / 19200 baud).

Ports:
- clk, input, 1: system clock; all logic is on the rising edge.
- rst, input, 1: reset, synchronous, active-high.
- cmd, input, 16: command word; [15:8] is sent first, then [7:0].
- send_cmd, input, 1: one-cycle request to transmit cmd.
- cmd_sent, output, 1: level; high once both bytes have fully left TX.
- RX, input, 1: serial data from the robot, asynchronous.
- TX, output, 1: serial data to the robot; idles high.
- resp, output, 8: last received response byte.
- resp_rdy, output, 1: level; high when resp holds a new byte.

Behaviour:
- Clock and reset: one clock domain, clk. rst is synchronous, active-high.
- Reset values: TX=1, cmd_sent=0, resp=0x00, resp_rdy=0, all FSMs idle, counters 0.
- Command capture: when send_cmd=1 in IDLE, latch cmd into a 16-bit register the same cycle. cmd may change afterwards without effect.
- send_cmd while busy (not IDLE) is ignored. It also does not clear cmd_sent or resp_rdy.
- Command FSM states and transitions:
  - IDLE: on send_cmd, go to HIGH.
  - HIGH: start the TX byte cmd[15:8]; wait for tx_done, then go to LOW.
  - LOW: start the TX byte cmd[7:0]; wait for tx_done, then go to IDLE and set cmd_sent.
- cmd_sent: set/reset flop. Cleared by an accepted send_cmd, set on completion of the low byte.
- Inter-byte gap: at most 2 clocks between the high byte's stop bit and the low byte's start bit.
- TX frame: start bit 0, then 8 data bits LSB first, then stop bit 1, each bit exactly BAUD_DIV clocks.
  - Total 10*BAUD_DIV clocks per byte, about 20*BAUD_DIV+4 clocks per command.
  - TX is registered (glitch-free).
- RX synchronisation: two flops, both reset to 1, then falling-edge detection in RX IDLE starts a frame.
- RX sampling:
  - Each bit is sampled at mid-bit: first sample BAUD_DIV/2 clocks after the edge (start bit), then every BAUD_DIV.
  - Shift 8 data bits LSB first, then sample the stop bit.
  - On the stop-bit sample, load resp and set resp_rdy. The stop-bit value is not checked.
  - Then return to RX IDLE; the next frame can start on the next falling edge.
- A start bit that reads 1 at its mid-point is a glitch: abort to RX IDLE with no output.
- resp_rdy: set on byte completion, cleared by an accepted send_cmd.
  - Set takes priority if both occur in the same cycle.
  - A new byte overwrites resp; there is no overrun flag.
- TX and RX operate independently and simultaneously.
- Reset mid-operation: the next edge forces idle. TX returns high, aborting any frame, and partial RX data is discarded.

Decomposition:
- Shared package: BAUD_DIV default, the ACK constant 8'hA5, and the command-FSM state enum.
- Sub-module uart_xcvr: an 8N1 transmitter/receiver pair parameterised by BAUD_DIV.
  - Ports: trmt, tx_data, tx_done, rx_rdy, rx_data, clr_rx_rdy.
- The top holds the capture register, the byte-select FSM and the cmd_sent/resp_rdy flops.

Test Plan:
- Reset, then idle 100 clocks -> TX=1, cmd_sent=0, resp_rdy=0, resp=0x00.
- send_cmd with cmd=16'h2000 (calibrate), BAUD_DIV=2604 -> TX carries byte 0x20 then 0x00, each bit 2604 clocks.
  - cmd_sent rises about 52080 clocks after send_cmd.
- Loopback TX→RX with cmd=16'h4001 (move north 1) -> resp_rdy after the second frame with resp=0x01.
  - resp changes to 0x40 after the first frame.
- Robot-side bench UART sends 0xA5 -> resp=0xA5 and resp_rdy=1 about 9.5*BAUD_DIV clocks after the start edge.
  - A following send_cmd clears resp_rdy.
- Pulse send_cmd with cmd=16'h6112 while mid-transmission of a prior command -> ignored; the original two bytes complete unchanged.
- Assert rst during bit 4 of a TX byte and during RX bit 3 -> TX=1 next cycle, no cmd_sent, no resp_rdy.
  - A subsequent clean command transmits correctly.
